// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: owns PCF, runs a single-outstanding req/ack fetch, feeds decode.
// Latency: an instruction acked at edge N appears on InstrD after edge N (1 instr/cycle at zero wait).
// Backpressure: StallF/StallD hold PC and IF/ID; an ack taken while stalled is parked in a hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // FETCH: request in flight at req_addr (== PCF).
    // HOLD:  response parked in hold_buf while the pipe is stalled; no request out.
    // DROP:  PCF was redirected while a request was pending; its response must be thrown away.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] hold_buf;

    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // A redirect is only trusted once decode is not stalled (operands are final).
    assign stall    = StallF | StallD;
    assign redirect = (PCSrcD | JumpD) & ~StallD;
    assign target   = JumpD ? PCJumpD : PCBranchD;
    assign pc_plus4 = PCF + 32'd4;

    // Request is gated by reset so nothing goes out while rst is held.
    assign imem_req  = ~rst & (state != S_HOLD);
    assign imem_addr = req_addr;

    // Fetch FSM, PC register, hold buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            PCF      <= RESET_PC;
            req_addr <= RESET_PC;
            hold_buf <= 32'h0;
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // Fetched word is on the wrong path: drop it, restart at target.
                            PCF      <= target;
                            req_addr <= target;
                            InstrD   <= NOP_INSTR;
                            ValidD   <= 1'b0;
                        end else if (!stall) begin
                            InstrD   <= imem_rdata;
                            PCPlus4D <= pc_plus4;
                            ValidD   <= 1'b1;
                            PCF      <= pc_plus4;
                            req_addr <= pc_plus4;
                        end else begin
                            // Pipe cannot take it yet; park it instead of refetching.
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                        end
                    end else begin
                        if (redirect) begin
                            // Old request stays on the bus until acked, then is discarded.
                            PCF    <= target;
                            InstrD <= NOP_INSTR;
                            ValidD <= 1'b0;
                            state  <= S_DROP;
                        end else if (!StallD) begin
                            InstrD <= NOP_INSTR;
                            ValidD <= 1'b0;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        PCF      <= target;
                        req_addr <= target;
                        InstrD   <= NOP_INSTR;
                        ValidD   <= 1'b0;
                        state    <= S_FETCH;
                    end else if (!stall) begin
                        InstrD   <= hold_buf;
                        PCPlus4D <= pc_plus4;
                        ValidD   <= 1'b1;
                        PCF      <= pc_plus4;
                        req_addr <= pc_plus4;
                        state    <= S_FETCH;
                    end else if (!StallD) begin
                        // Decode moves on but fetch is frozen: feed it a bubble.
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end
                end

                S_DROP: begin
                    if (redirect) begin
                        PCF <= target;
                    end
                    if (!StallD) begin
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end
                    if (imem_ack) begin
                        // Stale response retired; next request goes to the latest PC.
                        req_addr <= redirect ? target : PCF;
                        state    <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, zero-wait streaming, wait states, stall/hold,
// same-cycle branch, redirect over a pending request, mid-transaction reset and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int n_tests;
    int n_fail;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory content model: distinct, non-NOP word per address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    // One clock: inputs change on negedge, outputs sampled on negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        StallF = 0; StallD = 0; PCSrcD = 0; JumpD = 0;
        PCBranchD = 32'h0; PCJumpD = 32'h0; imem_ack = 0; imem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        n_tests++; if (PCF !== 32'h0) begin n_fail++; $display("FAIL rst_pcf got=%h exp=0", PCF); end
        n_tests++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", InstrD); end
        n_tests++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", ValidD); end
        n_tests++; if (PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL rst_pcp4 got=%h exp=0", PCPlus4D); end
        rst = 0;
        #1;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req got=%b exp=1", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        imem_ack = 1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            n_tests++; if (imem_addr !== a) begin n_fail++; $display("FAIL zw_addr%0d got=%h exp=%h", i, imem_addr, a); end
            imem_rdata = word(a);
            tick();
            n_tests++; if (InstrD !== word(a)) begin n_fail++; $display("FAIL zw_instr%0d got=%h exp=%h", i, InstrD, word(a)); end
            n_tests++; if (ValidD !== 1'b1) begin n_fail++; $display("FAIL zw_valid%0d got=%b exp=1", i, ValidD); end
            n_tests++; if (PCPlus4D !== a + 32'd4) begin n_fail++; $display("FAIL zw_pcp4%0d got=%h exp=%h", i, PCPlus4D, a + 32'd4); end
        end
        imem_ack = 0;
        tick();
        n_tests++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL zw_bubble got=%b exp=0", ValidD); end
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL ws_addr%0d got=%h/%b exp=0/1", i, imem_addr, imem_req); end
            n_tests++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL ws_valid%0d got=%b exp=0", i, ValidD); end
        end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ws_addr2 got=%h exp=0", imem_addr); end
        imem_ack = 1; imem_rdata = word(32'h0);
        tick();
        imem_ack = 0;
        n_tests++; if (InstrD !== word(32'h0) || ValidD !== 1'b1) begin n_fail++; $display("FAIL ws_instr got=%h/%b exp=%h/1", InstrD, ValidD, word(32'h0)); end
        n_tests++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL ws_next_addr got=%h exp=4", imem_addr); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        imem_ack = 1; imem_rdata = word(32'h0);
        tick();
        StallF = 1; StallD = 1; imem_rdata = word(32'h4);
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req_hold got=%b exp=0", imem_req); end
        n_tests++; if (InstrD !== word(32'h0) || ValidD !== 1'b1) begin n_fail++; $display("FAIL st_frozen1 got=%h/%b exp=%h/1", InstrD, ValidD, word(32'h0)); end
        n_tests++; if (PCF !== 32'h4) begin n_fail++; $display("FAIL st_pcf got=%h exp=4", PCF); end
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        n_tests++; if (InstrD !== word(32'h0) || imem_req !== 1'b0) begin n_fail++; $display("FAIL st_frozen2 got=%h/%b exp=%h/0", InstrD, imem_req, word(32'h0)); end
        StallF = 0; StallD = 0; imem_ack = 0;
        tick();
        n_tests++; if (InstrD !== word(32'h4) || ValidD !== 1'b1) begin n_fail++; $display("FAIL st_release got=%h/%b exp=%h/1", InstrD, ValidD, word(32'h4)); end
        n_tests++; if (PCPlus4D !== 32'h8) begin n_fail++; $display("FAIL st_pcp4 got=%h exp=8", PCPlus4D); end
        n_tests++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin n_fail++; $display("FAIL st_next_req got=%h/%b exp=8/1", imem_addr, imem_req); end
    endtask

    task automatic test_branch_same_cycle();
        do_reset();
        imem_ack = 1; imem_rdata = word(32'h0);
        tick();
        PCSrcD = 1; PCBranchD = 32'h40; imem_rdata = word(32'h4);
        tick();
        PCSrcD = 0;
        n_tests++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin n_fail++; $display("FAIL br_bubble got=%h/%b exp=0/0", InstrD, ValidD); end
        n_tests++; if (imem_addr !== 32'h40 || PCF !== 32'h40) begin n_fail++; $display("FAIL br_target got=%h/%h exp=40/40", imem_addr, PCF); end
        imem_rdata = word(32'h40);
        tick();
        imem_ack = 0;
        n_tests++; if (InstrD !== word(32'h40) || PCPlus4D !== 32'h44) begin n_fail++; $display("FAIL br_instr got=%h/%h exp=%h/44", InstrD, PCPlus4D, word(32'h40)); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        StallD = 1; PCSrcD = 1; PCBranchD = 32'h300;
        tick();
        n_tests++; if (PCF !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rd_stalld_ignored got=%h/%h exp=0/0", PCF, imem_addr); end
        StallD = 0; PCBranchD = 32'h200; JumpD = 1; PCJumpD = 32'h10;
        imem_ack = 1; imem_rdata = word(32'h0);
        tick();
        JumpD = 0;
        n_tests++; if (PCF !== 32'h10 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_jump_prio got=%h/%h exp=10/10", PCF, imem_addr); end
        PCBranchD = 32'h80; imem_ack = 0;
        tick();
        PCSrcD = 0;
        n_tests++; if (PCF !== 32'h80) begin n_fail++; $display("FAIL rd_pcf got=%h exp=80", PCF); end
        n_tests++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_old_req got=%h/%b exp=10/1", imem_addr, imem_req); end
        tick();
        n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL rd_old_req2 got=%h exp=10", imem_addr); end
        imem_ack = 1; imem_rdata = word(32'h10);
        tick();
        n_tests++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin n_fail++; $display("FAIL rd_discard got=%h/%b exp=0/0", InstrD, ValidD); end
        n_tests++; if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL rd_new_addr got=%h exp=80", imem_addr); end
        imem_rdata = word(32'h80);
        tick();
        imem_ack = 0;
        n_tests++; if (InstrD !== word(32'h80) || ValidD !== 1'b1 || PCPlus4D !== 32'h84) begin n_fail++; $display("FAIL rd_instr got=%h/%b/%h exp=%h/1/84", InstrD, ValidD, PCPlus4D, word(32'h80)); end
    endtask

    task automatic test_reset_mid_wait_and_wrap();
        do_reset();
        imem_ack = 1; imem_rdata = word(32'h0);
        tick();
        imem_ack = 0; StallD = 1;
        tick();
        n_tests++; if (ValidD !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL mr_pre got=%b/%h exp=1/4", ValidD, imem_addr); end
        rst = 1;
        #1;
        n_tests++; if (imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== 32'h0 || PCF !== 32'h0) begin n_fail++; $display("FAIL mr_async got=%b/%b/%h/%h exp=0/0/0/0", imem_req, ValidD, InstrD, PCF); end
        tick();
        rst = 0; StallD = 0;
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mr_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
        JumpD = 1; PCJumpD = 32'hFFFF_FFFC; imem_ack = 1; imem_rdata = word(32'h0);
        tick();
        JumpD = 0;
        n_tests++; if (PCF !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_pcf got=%h exp=fffffffc", PCF); end
        imem_rdata = word(32'hFFFF_FFFC);
        tick();
        imem_ack = 0;
        n_tests++; if (InstrD !== word(32'hFFFF_FFFC) || PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL wr_instr got=%h/%h exp=%h/0", InstrD, PCPlus4D, word(32'hFFFF_FFFC)); end
        n_tests++; if (PCF !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_wrap got=%h/%h exp=0/0", PCF, imem_addr); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_branch_same_cycle();
        test_redirect_pending();
        test_reset_mid_wait_and_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
